// File: rtl/accelbrot_com_pkg.sv
// Shared types and constants for the accelbrot word-serial add/sub block.
package accelbrot_com_pkg;

  localparam int WWIDTH_DEFAULT = 34;
  localparam int CHW_DEFAULT    = 2;

  // Channel id at the default channel-id width
  typedef logic [CHW_DEFAULT-1:0] ch_id_t;

  // Number of interleaved channels for a given channel-id width
  function automatic int num_ch(input int chw);
    return 1 << chw;
  endfunction

endpackage

// File: rtl/accelbrot_com_addsub_if.sv
// Operand/result stream bundle for accelbrot_com_addsub.
// slave: the add/sub block's view; master: the producer/consumer view.
interface accelbrot_com_addsub_if #(
  parameter int WWIDTH = 34,
  parameter int CHW    = 2
);
  logic [WWIDTH-1:0] a;
  logic [WWIDTH-1:0] b;
  logic [CHW-1:0]    ab_ch;
  logic              ab_sub;
  logic              ab_start;
  logic              ab_last;
  logic              ab_valid;
  logic              ab_ready;

  logic [WWIDTH-1:0] q;
  logic [CHW-1:0]    q_ch;
  logic              q_start;
  logic              q_last;
  logic              q_valid;
  logic              q_ovf;
  logic              q_ready;

  modport slave (
    input  a, b, ab_ch, ab_sub, ab_start, ab_last, ab_valid, q_ready,
    output ab_ready, q, q_ch, q_start, q_last, q_valid, q_ovf
  );

  modport master (
    output a, b, ab_ch, ab_sub, ab_start, ab_last, ab_valid, q_ready,
    input  ab_ready, q, q_ch, q_start, q_last, q_valid, q_ovf
  );
endinterface

// File: rtl/accelbrot_com_reg_slice.sv
// One-stage valid/ready register slice. Accepts a new word whenever the
// stage is empty or being drained this cycle, so a full stream moves with
// no bubbles; holds its contents stable while stalled.
module accelbrot_com_reg_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  logic [DW-1:0] data_q, data_d;
  logic          vld_q, vld_d;

  assign in_ready  = !vld_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = vld_q;

  // Load on accept, empty on drain-without-refill, otherwise hold
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (in_ready) begin
      vld_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // Stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: rtl/accelbrot_com_addsub.sv
// Word-serial multi-word adder/subtractor with 2**CHW interleaved channels.
// Each channel keeps its own carry and add/sub mode; a start word resets
// the channel (cin = sub, mode latched), later words chain the carry.
// Optional: define ACCELBROT_ADDSUB_OVF_EN to report signed overflow on
// the last word; otherwise q_ovf is tied low.
module accelbrot_com_addsub
  import accelbrot_com_pkg::*;
#(
  parameter int WWIDTH = WWIDTH_DEFAULT,
  parameter int CHW    = CHW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  accelbrot_com_addsub_if.slave bus
);
  localparam int NCH = 1 << CHW;
  localparam int DW  = WWIDTH + CHW + 3;

  logic [NCH-1:0]    carry_q, carry_d;
  logic [NCH-1:0]    mode_q, mode_d;

  logic              accept;
  logic              in_ready;
  logic              mode;
  logic              cin;
  logic [WWIDTH-1:0] bx;
  logic [WWIDTH:0]   tmp;
  logic              ovf;
  logic [DW-1:0]     pl_in, pl_out;

  assign accept = bus.ab_valid && in_ready;

  // Operand select and adder; mode/carry come from the start word or the
  // channel's stored state
  always_comb begin
    mode = mode_q[bus.ab_ch];
    cin  = carry_q[bus.ab_ch];
    if (bus.ab_start) begin
      mode = bus.ab_sub;
      cin  = bus.ab_sub;
    end
    bx  = mode ? ~bus.b : bus.b;
    tmp = {1'b0, bus.a} + {1'b0, bx} + {{WWIDTH{1'b0}}, cin};
  end

`ifdef ACCELBROT_ADDSUB_OVF_EN
  // Signed overflow: carry into MSB xor carry out of MSB, last word only
  always_comb begin
    ovf = bus.ab_last &&
          ((bus.a[WWIDTH-1] ^ bx[WWIDTH-1] ^ tmp[WWIDTH-1]) ^ tmp[WWIDTH]);
  end
`else
  assign ovf = 1'b0;
`endif

  // Per-channel state only moves when a word is actually accepted
  always_comb begin
    carry_d = carry_q;
    mode_d  = mode_q;
    if (accept) begin
      carry_d[bus.ab_ch] = tmp[WWIDTH];
      if (bus.ab_start) mode_d[bus.ab_ch] = bus.ab_sub;
    end
  end

  // Carry/mode arrays
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= '0;
      mode_q  <= '0;
    end else begin
      carry_q <= carry_d;
      mode_q  <= mode_d;
    end
  end

  assign pl_in = {tmp[WWIDTH-1:0], bus.ab_ch, bus.ab_start, bus.ab_last, ovf};

  accelbrot_com_reg_slice #(.DW(DW)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_data   (pl_in),
    .in_valid  (bus.ab_valid),
    .in_ready  (in_ready),
    .out_data  (pl_out),
    .out_valid (bus.q_valid),
    .out_ready (bus.q_ready)
  );

  assign bus.ab_ready = in_ready;
  assign bus.q        = pl_out[DW-1 -: WWIDTH];
  assign bus.q_ch     = pl_out[CHW+2 -: CHW];
  assign bus.q_start  = pl_out[2];
  assign bus.q_last   = pl_out[1];
  assign bus.q_ovf    = pl_out[0];
endmodule

// File: tb/tb_accelbrot_com_addsub.sv
// Directed bench for accelbrot_com_addsub at WWIDTH=8, CHW=2.
module tb_accelbrot_com_addsub;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  accelbrot_com_addsub_if #(.WWIDTH(8), .CHW(2)) bus ();

  accelbrot_com_addsub #(.WWIDTH(8), .CHW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACCELBROT_ADDSUB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for one cycle; q_ready assumed high so it is accepted
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] ch,
                      input logic sub, input logic st, input logic la);
    bus.a = a; bus.b = b; bus.ab_ch = ch; bus.ab_sub = sub;
    bus.ab_start = st; bus.ab_last = la; bus.ab_valid = 1'b1;
    @(posedge clk); #1;
    bus.ab_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] q, input logic [1:0] ch,
                         input logic st, input logic la, input logic ovf);
    chk({tag, ".q"}, {24'h0, bus.q}, {24'h0, q});
    chk({tag, ".ch"}, {30'h0, bus.q_ch}, {30'h0, ch});
    chk({tag, ".flags"}, {28'h0, bus.q_valid, bus.q_start, bus.q_last, bus.q_ovf},
        {28'h0, 1'b1, st, la, ovf});
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    bus.a = '0; bus.b = '0; bus.ab_ch = '0; bus.ab_sub = 1'b0;
    bus.ab_start = 1'b0; bus.ab_last = 1'b0; bus.ab_valid = 1'b0; bus.q_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", {24'h0, bus.q}, 32'h0);
    chk("rst.flags", {26'h0, bus.q_ch, bus.q_valid, bus.q_start, bus.q_last, bus.q_ovf}, 32'h0);
    chk("rst.ab_ready", {31'h0, bus.ab_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word add on ch0: 0x00FF + 0x0001 = 0x0100
    send(8'hFF, 8'h01, 2'd0, 1'b0, 1'b1, 1'b0);
    chk_out("add0.w0", 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    send(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
    chk_out("add0.w1", 8'h01, 2'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("drain.valid", {31'h0, bus.q_valid}, 32'h0);

    // Two-word subtract on ch1: 0x0100 - 0x0001 = 0x00FF
    send(8'h00, 8'h01, 2'd1, 1'b1, 1'b1, 1'b0);
    chk_out("sub1.w0", 8'hFF, 2'd1, 1'b1, 1'b0, 1'b0);
    send(8'h01, 8'h00, 2'd1, 1'b0, 1'b0, 1'b1);
    chk_out("sub1.w1", 8'h00, 2'd1, 1'b0, 1'b1, 1'b0);

    // Interleaved ch0 add and ch2 sub, back to back
    send(8'hFF, 8'h01, 2'd0, 1'b0, 1'b1, 1'b0);
    chk_out("il.c0w0", 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    send(8'h05, 8'h07, 2'd2, 1'b1, 1'b1, 1'b0);
    chk_out("il.c2w0", 8'hFE, 2'd2, 1'b1, 1'b0, 1'b0);
    send(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
    chk_out("il.c0w1", 8'h01, 2'd0, 1'b0, 1'b1, 1'b0);
    send(8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b1);
    chk_out("il.c2w1", 8'hFF, 2'd2, 1'b0, 1'b1, 1'b0);

    // Back-pressure: hold output 3 cycles with next word pending
    send(8'h10, 8'h20, 2'd3, 1'b0, 1'b1, 1'b0);
    chk_out("stall.w0", 8'h30, 2'd3, 1'b1, 1'b0, 1'b0);
    bus.q_ready = 1'b0;
    bus.a = 8'h01; bus.b = 8'h02; bus.ab_ch = 2'd3; bus.ab_sub = 1'b0;
    bus.ab_start = 1'b0; bus.ab_last = 1'b1; bus.ab_valid = 1'b1;
    #1;
    chk("stall.ab_ready", {31'h0, bus.ab_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall.ab_ready", {31'h0, bus.ab_ready}, 32'h0);
      chk_out("stall.hold", 8'h30, 2'd3, 1'b1, 1'b0, 1'b0);
    end
    bus.q_ready = 1'b1;
    #1;
    chk("stall.release", {31'h0, bus.ab_ready}, 32'h1);
    @(posedge clk); #1;
    bus.ab_valid = 1'b0;
    chk_out("stall.w1", 8'h03, 2'd3, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("stall.nodup", {31'h0, bus.q_valid}, 32'h0);

    // Start word mid-operation aborts the previous carry chain
    send(8'hFF, 8'h01, 2'd0, 1'b0, 1'b1, 1'b0);
    send(8'h01, 8'h01, 2'd0, 1'b0, 1'b1, 1'b1);
    chk_out("abort", 8'h02, 2'd0, 1'b1, 1'b1, 1'b0);

    // Single-word signed overflow
    send(8'h7F, 8'h01, 2'd1, 1'b0, 1'b1, 1'b1);
    chk_out("ovf", 8'h80, 2'd1, 1'b1, 1'b1, OVF_EXP);

    // Reset mid-operation; ch2 carry and ch3 mode must both clear
    send(8'h00, 8'h00, 2'd3, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 2'd2, 1'b0, 1'b1, 1'b0);
    chk_out("prerst", 8'hFE, 2'd2, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.q", {24'h0, bus.q}, 32'h0);
    chk("midrst.flags", {26'h0, bus.q_ch, bus.q_valid, bus.q_start, bus.q_last, bus.q_ovf}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h03, 8'h04, 2'd2, 1'b0, 1'b0, 1'b1);
    chk_out("postrst.c2", 8'h07, 2'd2, 1'b0, 1'b1, 1'b0);
    send(8'h03, 8'h04, 2'd3, 1'b0, 1'b0, 1'b1);
    chk_out("postrst.c3", 8'h07, 2'd3, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accelbrot_com_addsub.md
ACCELBROT_COM_ADDSUB -- requirements
Module: accelbrot_com_addsub

Interface
REQ-001 SHALL have parameter WWIDTH, default 34, word width in bits.
REQ-002 SHALL have parameter CHW, default 2, channel-id width; 2**CHW interleaved channels.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-004 SHALL have inputs: a, b (WWIDTH) operand words, LS word first; ab_ch (CHW) channel id; ab_sub (1) subtract mode, sampled on start word only; ab_start, ab_last, ab_valid (1 each).
REQ-005 SHALL have output ab_ready (1), input accepted when ab_valid && ab_ready.
REQ-006 SHALL have outputs: q (WWIDTH); q_ch (CHW); q_start, q_last, q_valid, q_ovf (1 each); and input q_ready (1).

Function
REQ-007 SHALL add or subtract two multi-word integers presented word-serially, with an independent carry and mode per channel.
REQ-008 On an accepted start word: mode[ch] <= ab_sub; cin = ab_sub; otherwise cin = carry[ch] and the mode used is mode[ch].
REQ-009 Per word: tmp(WWIDTH+1) = a + (mode ? ~b : b) + cin; q <= tmp[WWIDTH-1:0]; carry[ch] <= tmp[WWIDTH].
REQ-010 Latency: exactly 1 cycle from acceptance to q_valid when the output is free.
REQ-011 q_ch, q_start and q_last SHALL be registered copies of the accepted word's ab_ch, ab_start and ab_last.
REQ-012 ab_ready = !q_valid || q_ready, combinational.
REQ-013 While q_valid && !q_ready: q, q_ch, q_start, q_last, q_ovf and q_valid SHALL hold stable, and no carry or mode SHALL update.
REQ-014 If an output word is consumed with no new input accepted in the same cycle, q_valid SHALL fall to 0 the next cycle.
REQ-015 Input accepted and output consumed in the same cycle: the new word SHALL be loaded with no bubble.
REQ-016 ab_start && ab_last together: single-word operation; cin = ab_sub.
REQ-017 A non-start word on a channel with no prior start SHALL use the stored carry and mode (reset values 0, add); no error is flagged.
REQ-018 Words of different channels MAY interleave arbitrarily; a channel's carry SHALL be affected only by its own words.
REQ-019 A start word on a channel mid-operation SHALL abort the old operation silently and begin a new one.

Reset
REQ-020 On rst: q, q_ch, q_start, q_last, q_valid and q_ovf SHALL be 0; all carry[] = 0; all mode[] = 0 (add).
REQ-021 Reset asserted mid-operation SHALL discard all in-flight state; the first word after reset SHALL be treated per REQ-017 unless it is a start.

Configuration
REQ-022 Macro ACCELBROT_ADDSUB_OVF_EN defined: q_ovf = signed two's-complement overflow of the full result, computed on the last word as carry into MSB XOR carry out of MSB; q_ovf is 0 on non-last words.
REQ-023 Macro undefined: the q_ovf port still exists, is tied to 0, and no overflow logic is built.

Structure
REQ-024 Package accelbrot_com_pkg SHALL hold the typedef for the channel id (sized from CHW) and the default WWIDTH constant.
REQ-025 The output register plus ready logic SHALL be the sub-module accelbrot_com_reg_slice (data-width parameterised, 1 stage); the carry/mode arrays and adder stay in the top module.

Verification (bench uses WWIDTH=8, CHW=2)
REQ-026 Add ch0: (a,b) = (FF,01) start, then (00,00) last -> q = 00 then 01, q_ovf = 0.
REQ-027 Subtract ch1: (00,01) start with sub=1, then (01,00) last -> q = FF then 00, i.e. 0x0100 - 1 = 0x00FF.
REQ-028 Interleave ch0 add (FF,01),(00,00) with ch2 sub (05,07),(00,00), alternating words -> ch0 gives 00, 01; ch2 gives FE, FF; no carry cross-talk.
REQ-029 q_ready low for 3 cycles with ab_valid high -> ab_ready = 0 and outputs stable for 3 cycles; after release, the next word follows with no loss or duplication.
REQ-030 Single word 7F+01 with start and last -> q = 80, q_ovf = 1 with the macro and 0 without; then assert rst mid two-word operation -> all outputs 0, and a following non-start word 03+04 gives 07.
